// File: rtl/mem_arbiter.sv
// Shared cache / external memory sequencer for fetch and data requesters.
// Optional macro ROUND_ROBIN_EN: alternate fetch/data priority on contention.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int LINE_BYTES  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [7:0]        if_rdata,
  input  logic              dt_req,
  input  logic              dt_we,
  input  logic [ADDR_W-1:0] dt_addr,
  input  logic [7:0]        dt_wdata,
  output logic              dt_gnt,
  output logic              dt_valid,
  output logic [7:0]        dt_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_w_rd,
  output logic [7:0]        c_wdata,
  input  logic [7:0]        c_rdata,
  input  logic              c_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam int OFF = $clog2(LINE_BYTES);
  localparam int TW  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [OFF-1:0] LAST = OFF'(LINE_BYTES - 1);
  localparam logic [TW-1:0]  TLIM = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, FILL_REQ, FILL_GAP, WR_CACHE, WR_MEM, RESP
  } state_t;

  state_t            state, state_nx;
  logic              owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        rdata_q;
  logic [OFF-1:0]    beat;
  logic [TW-1:0]     tcnt;
  logic              err_q;
  logic              pick_dt;
  logic              accept;
  logic              mem_st;
  logic              tmo;
  logic [ADDR_W-1:0] fill_addr;

`ifdef ROUND_ROBIN_EN
  logic pref_dt;
  assign pick_dt = dt_req && (!if_req || pref_dt);
`else
  assign pick_dt = dt_req;
`endif

  assign accept    = (state == IDLE) && (if_req || dt_req);
  assign mem_st    = (state == FILL_REQ) || (state == WR_MEM);
  assign tmo       = mem_st && !mem_ack && (tcnt == TLIM);
  assign fill_addr = {addr_q[ADDR_W-1:OFF], beat};
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Latched request, beat/timeout counters and captured response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      beat    <= '0;
      tcnt    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        owner   <= pick_dt;
        we_q    <= pick_dt & dt_we;
        addr_q  <= pick_dt ? dt_addr : if_addr;
        wdata_q <= pick_dt ? dt_wdata : 8'h00;
        rdata_q <= 8'h00;
        err_q   <= 1'b0;
      end
      if (state == LOOKUP) begin
        beat <= '0;
        if (!we_q && c_hit) rdata_q <= c_rdata;
      end
      if (state == FILL_REQ && mem_ack) beat <= beat + 1'b1;
      if (tmo) begin
        err_q   <= 1'b1;
        rdata_q <= 8'h00;
      end
      tcnt <= (mem_st && state_nx == state) ? tcnt + 1'b1 : '0;
    end
  end

`ifdef ROUND_ROBIN_EN
  // The requester that just lost priority gets it next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pref_dt <= 1'b1;
    else if (accept) pref_dt <= !pick_dt;
  end
`endif

  // Next state and all outputs; grants are masked while reset is held.
  always_comb begin
    state_nx  = state;
    if_gnt    = 1'b0;
    if_valid  = 1'b0;
    if_rdata  = 8'h00;
    dt_gnt    = 1'b0;
    dt_valid  = 1'b0;
    dt_rdata  = 8'h00;
    err       = 1'b0;
    c_addr    = '0;
    c_w_rd    = 1'b0;
    c_wdata   = 8'h00;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = LOOKUP;
          dt_gnt   = pick_dt & !rst;
          if_gnt   = !pick_dt & !rst;
        end
      end
      LOOKUP: begin
        c_addr = addr_q;
        if (we_q) state_nx = c_hit ? WR_CACHE : WR_MEM;
        else      state_nx = c_hit ? RESP : FILL_REQ;
      end
      FILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = fill_addr;
        c_addr   = fill_addr;
        if (mem_ack) begin
          c_w_rd   = 1'b1;
          c_wdata  = mem_rdata;
          state_nx = (beat == LAST) ? LOOKUP : FILL_GAP;
        end else if (tmo) begin
          state_nx = RESP;
        end
      end
      FILL_GAP: state_nx = FILL_REQ;
      WR_CACHE: begin
        c_w_rd   = 1'b1;
        c_addr   = addr_q;
        c_wdata  = wdata_q;
        state_nx = WR_MEM;
      end
      WR_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack || tmo) state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
        err      = err_q;
        if (owner) begin
          dt_valid = 1'b1;
          dt_rdata = we_q ? 8'h00 : rdata_q;
        end else begin
          if_valid = 1'b1;
          if_rdata = rdata_q;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
